// File: rtl/qerv_dbus_ram.sv
`default_nettype none
// ============================================================================
// Module  : qerv_dbus_ram
// Brief   : Wishbone-style data-bus RAM with a programmable response latency.
//           Define QERV_DBUS_ERR_EN to flag out-of-range addresses on o_wb_err.
// Revision: 1.0 - initial release
// ============================================================================
module qerv_dbus_ram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
`ifdef QERV_DBUS_ERR_EN
  ,
  output logic        o_wb_err
`endif
);

  localparam int         AW          = $clog2(DEPTH);
  localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_capture;

  logic [AW-1:0] r_idx;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_range_err;
  logic          w_range_err_in;
  logic          w_resp_live;
  logic          w_wr;
  logic          w_unused;

  logic [31:0]   r_mem [DEPTH];

`ifdef QERV_DBUS_ERR_EN
  assign w_range_err_in = |i_wb_adr[31:AW+2];
  assign w_unused       = ^i_wb_adr[1:0];
`else
  // Upper address bits are dropped so accesses wrap within the array.
  assign w_range_err_in = 1'b0;
  assign w_unused       = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_wb_cyc) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_range_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_idx       <= i_wb_adr[AW+1:2];
        r_dat       <= i_wb_dat;
        r_sel       <= i_wb_sel;
        r_we        <= i_wb_we;
        r_range_err <= w_range_err_in;
      end
    end
  end

  // A response only counts while the core still holds cyc; dropping it aborts.
  assign w_resp_live = (r_state == S_RESP) && i_wb_cyc;
  assign o_wb_ack    = w_resp_live && !r_range_err;
  assign o_wb_rdt    = o_wb_ack ? r_mem[r_idx] : 32'h0;
  assign w_wr        = o_wb_ack && r_we;

`ifdef QERV_DBUS_ERR_EN
  assign o_wb_err = w_resp_live && r_range_err;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qerv_dbus_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_qerv_dbus_ram
// Brief   : Self-checking bench for qerv_dbus_ram over four wait-state settings.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qerv_dbus_ram;

  localparam int NDUT  = 4;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       rst_n;
  logic [NDUT-1:0]       cyc;
  logic [NDUT-1:0]       we;
  logic [NDUT-1:0][31:0] adr;
  logic [NDUT-1:0][31:0] dat;
  logic [NDUT-1:0][3:0]  sel;
  wire  [NDUT-1:0]       ack;
  wire  [NDUT-1:0]       err;
  wire  [NDUT-1:0][31:0] rdt;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    qerv_dbus_ram #(
      .DEPTH       (DEPTH),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n[g]),
      .i_wb_adr (adr[g]),
      .i_wb_dat (dat[g]),
      .i_wb_sel (sel[g]),
      .i_wb_we  (we[g]),
      .i_wb_cyc (cyc[g]),
      .o_wb_rdt (rdt[g]),
      .o_wb_ack (ack[g])
`ifdef QERV_DBUS_ERR_EN
      ,
      .o_wb_err (err[g])
`endif
    );
  end

`ifndef QERV_DBUS_ERR_EN
  assign err = '0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%h exp=%h at %0t", name, d, got, exp, $time);
    end
  endtask

  // Transaction-level reference: a request answers WAIT_STATES+1 edges after capture.
  bit          m_busy  [NDUT];
  int          m_age   [NDUT];
  logic [31:0] m_adr   [NDUT];
  logic [31:0] m_dat   [NDUT];
  logic [3:0]  m_sel   [NDUT];
  bit          m_we    [NDUT];
  logic [31:0] m_mem   [NDUT][DEPTH];
  bit          m_known [NDUT][DEPTH];

  function automatic bit m_rng_err(input int d);
`ifdef QERV_DBUS_ERR_EN
    return (m_adr[d] >> (AW + 2)) != 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input int d);
    return int'(m_adr[d][AW+1:2]);
  endfunction

  function automatic bit m_resp(input int d);
    return m_busy[d] && (m_age[d] == ws_of(d) + 1) && cyc[d];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n[d]) begin
        m_busy[d] = 1'b0;
      end else if (m_busy[d]) begin
        if (!cyc[d]) begin
          m_busy[d] = 1'b0;
        end else if (m_age[d] == ws_of(d) + 1) begin
          if (m_we[d] && !m_rng_err(d)) begin
            for (int b = 0; b < 4; b++) begin
              if (m_sel[d][b]) m_mem[d][m_idx(d)][8*b +: 8] = m_dat[d][8*b +: 8];
            end
            if (m_sel[d] == 4'hF) m_known[d][m_idx(d)] = 1'b1;
          end
          m_busy[d] = 1'b0;
        end else begin
          m_age[d]++;
        end
      end else if (cyc[d]) begin
        m_adr[d]  = adr[d];
        m_dat[d]  = dat[d];
        m_sel[d]  = sel[d];
        m_we[d]   = we[d];
        m_busy[d] = 1'b1;
        m_age[d]  = 1;
      end
    end
  end

  bit run_cmp = 1'b0;

  always @(negedge clk) begin
    logic ea;
    logic ee;
    if (run_cmp) begin
      for (int d = 0; d < NDUT; d++) begin
        ea = m_resp(d) && !m_rng_err(d);
        ee = m_resp(d) && m_rng_err(d);
        check("cyc_ack", d, 32'(ack[d]), 32'(ea));
`ifdef QERV_DBUS_ERR_EN
        check("cyc_err", d, 32'(err[d]), 32'(ee));
`endif
        if (!ea) check("cyc_rdt_zero", d, rdt[d], 32'h0);
        else if (m_known[d][m_idx(d)]) check("cyc_rdt", d, rdt[d], m_mem[d][m_idx(d)]);
      end
    end
  end

  // Starts just after a rising edge; returns just after a rising edge with cyc low.
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                     input bit w, output logic [31:0] r, output int lat, output bit e);
    adr[d] = a; dat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
    lat = 0; r = 32'h0; e = 1'b0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack[d] || err[d]) begin
        r = rdt[d];
        e = err[d];
        break;
      end
      if (lat > 40) begin
        check("req_timeout", d, 32'(lat), 32'(ws_of(d) + 1));
        break;
      end
    end
    @(posedge clk);
    #1;
    cyc[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s, input int exp_lat);
    logic [31:0] r;
    int          lat;
    bit          e;
    req(d, a, v, s, 1'b1, r, lat, e);
    check("wr_latency", d, 32'(lat), 32'(exp_lat));
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int          lat;
    bit          e;
    req(d, a, 32'h0, 4'h0, 1'b0, r, lat, e);
    check("rd_latency", d, 32'(lat), 32'(exp_lat));
    check("rd_data", d, r, exp);
  endtask

  task automatic count_acks(input int d, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ack[d]) n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = '0; cyc = '0; we = '0; adr = '0; dat = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("rst_ack", d, 32'(ack[d]), 32'h0);
      check("rst_rdt", d, rdt[d], 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = '1;

    // Full-word write/read and byte-lane merge, one wait state.
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 2);
    rd(0, 32'h10, 32'hDEADBEEF, 2);
    wr(0, 32'h20, 32'h11223344, 4'hF, 2);
    wr(0, 32'h20, 32'hAABBCCDD, 4'b0101, 2);
    rd(0, 32'h20, 32'h11BB33DD, 2);

    // Zero wait states, back-to-back reads with cyc held.
    wr(1, 32'h0, 32'hA5A50001, 4'hF, 1);
    wr(1, 32'h4, 32'h5A5A0002, 4'hF, 1);
    adr[1] = 32'h0; we[1] = 1'b0; sel[1] = 4'h0; cyc[1] = 1'b1;
    @(posedge clk);
    #1;
    adr[1] = 32'h4;
    @(negedge clk);
    check("b2b_ack0", 1, 32'(ack[1]), 32'h1);
    check("b2b_rdt0", 1, rdt[1], 32'hA5A50001);
    @(negedge clk);
    check("b2b_gap", 1, 32'(ack[1]), 32'h0);
    @(negedge clk);
    check("b2b_ack1", 1, 32'(ack[1]), 32'h1);
    check("b2b_rdt1", 1, rdt[1], 32'h5A5A0002);
    @(posedge clk);
    #1;
    cyc[1] = 1'b0;

    // Abort after one cycle, three wait states.
    wr(2, 32'h30, 32'h0BADF00D, 4'hF, 4);
    adr[2] = 32'h30; dat[2] = 32'hFFFFFFFF; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
    @(posedge clk);
    #1;
    cyc[2] = 1'b0; we[2] = 1'b0;
    count_acks(2, 8, n);
    check("abort_noack", 2, 32'(n), 32'h0);
    rd(2, 32'h30, 32'h0BADF00D, 4);

    // Captured request is immune to later input changes.
    adr[2] = 32'h34; dat[2] = 32'h12345678; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
    @(posedge clk);
    #1;
    adr[2] = 32'h38; dat[2] = 32'h0; sel[2] = 4'h0; we[2] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midchg_ack", 2, 32'(ack[2]), 32'h1);
    @(posedge clk);
    #1;
    cyc[2] = 1'b0;
    rd(2, 32'h34, 32'h12345678, 4);

    // Reset while waiting abandons the write.
    adr[2] = 32'h30; dat[2] = 32'h0; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b0; cyc[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    @(negedge clk);
    check("postrst_ack", 2, 32'(ack[2]), 32'h0);
    check("postrst_rdt", 2, rdt[2], 32'h0);
    count_acks(2, 6, n);
    check("postrst_noack", 2, 32'(n), 32'h0);
    rd(2, 32'h30, 32'h0BADF00D, 4);

    // Maximum wait states.
    wr(3, 32'h8, 32'h13579BDF, 4'hF, 16);
    rd(3, 32'h8, 32'h13579BDF, 16);

    // Address beyond the array.
    wr(0, 32'h0, 32'hCAFE0000, 4'hF, 2);
`ifdef QERV_DBUS_ERR_EN
    begin
      logic [31:0] r;
      int          lat;
      bit          e;
      req(0, 32'h400, 32'h0, 4'hF, 1'b1, r, lat, e);
      check("oor_err", 0, 32'(e), 32'h1);
      check("oor_lat", 0, 32'(lat), 32'h2);
      req(0, 32'h400, 32'h0, 4'hF, 1'b0, r, lat, e);
      check("oor_rd_err", 0, 32'(e), 32'h1);
      check("oor_rd_rdt", 0, r, 32'h0);
      rd(0, 32'h0, 32'hCAFE0000, 2);
    end
`else
    rd(0, 32'h400, 32'hCAFE0000, 2);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
